// File: rtl/bru_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : bru_pkg
//  Brief   : Branch opcode encodings and decode helpers shared between the
//            branch resolution unit and the control unit.
//  Rev     : 1.0  initial release
// ============================================================================
package bru_pkg;

    localparam logic [4:0] BROP_NONE     = 5'b00000;
    localparam logic [4:0] BROP_BEQ      = 5'b01000;
    localparam logic [4:0] BROP_BNE      = 5'b01001;
    localparam logic [4:0] BROP_BLT      = 5'b01100;
    localparam logic [4:0] BROP_BGE      = 5'b01101;
    localparam logic [4:0] BROP_BLTU     = 5'b01110;
    localparam logic [4:0] BROP_BGEU     = 5'b01111;
    localparam int         BROP_JUMP_BIT = 4;

    // True only for the six conditional branch codes; reserved 01010/01011,
    // no-branch and unconditional jumps all return 0.
    function automatic logic is_cond_branch(input logic [4:0] br_op);
        logic r;
        r = 1'b0;
        case (br_op)
            BROP_BEQ, BROP_BNE,
            BROP_BLT, BROP_BGE,
            BROP_BLTU, BROP_BGEU: r = 1'b1;
            default:              r = 1'b0;
        endcase
        return r;
    endfunction

endpackage : bru_pkg
`default_nettype wire

// File: rtl/bru_cmp.sv
`default_nettype none
// ============================================================================
//  Module  : bru_cmp
//  Brief   : Operand comparator for branch resolution. Produces equality,
//            signed less-than and unsigned less-than flags.
//  Rev     : 1.0  initial release
// ============================================================================
module bru_cmp #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            eq_o,
    output logic            lt_s_o,
    output logic            lt_u_o
);

    // Three independent flags; the opcode mux derives NE/GE/GEU by inversion.
    always_comb begin
        eq_o   = (rs1_i == rs2_i);
        lt_s_o = ($signed(rs1_i) < $signed(rs2_i));
        lt_u_o = (rs1_i < rs2_i);
    end

endmodule : bru_cmp
`default_nettype wire

// File: rtl/bru.sv
`default_nettype none
// ============================================================================
//  Module  : bru
//  Brief   : Branch resolution unit for the single-cycle RV32I core. Resolves
//            the PC source combinationally from two register operands and a
//            branch opcode, and keeps clocked branch statistics.
//  Rev     : 1.0  initial release
// ============================================================================
module bru
    import bru_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  ru_rs1,
    input  logic [XLEN-1:0]  ru_rs2,
    input  logic [4:0]       brOp,
    output logic             NextPCSrc,
    output logic             taken_q,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    logic             w_eq;
    logic             w_lt_s;
    logic             w_lt_u;
    logic             w_is_cond;
    logic             taken_d;
    logic [CNT_W-1:0] br_cnt_q;
    logic [CNT_W-1:0] br_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q;
    logic [CNT_W-1:0] taken_cnt_d;

    bru_cmp #(
        .XLEN (XLEN)
    ) u_cmp (
        .rs1_i  (ru_rs1),
        .rs2_i  (ru_rs2),
        .eq_o   (w_eq),
        .lt_s_o (w_lt_s),
        .lt_u_o (w_lt_u)
    );

    // Opcode mux: the jump bit is tested first so unconditional jumps never
    // depend on the comparator flags (no X from undriven operands).
    always_comb begin
        NextPCSrc = 1'b0;
        if (brOp[BROP_JUMP_BIT]) begin
            NextPCSrc = 1'b1;
        end else begin
            case (brOp)
                BROP_BEQ:  NextPCSrc = w_eq;
                BROP_BNE:  NextPCSrc = ~w_eq;
                BROP_BLT:  NextPCSrc = w_lt_s;
                BROP_BGE:  NextPCSrc = ~w_lt_s;
                BROP_BLTU: NextPCSrc = w_lt_u;
                BROP_BGEU: NextPCSrc = ~w_lt_u;
                default:   NextPCSrc = 1'b0;
            endcase
        end
    end

    // Statistics next-state: only conditional branches count; counters wrap.
    always_comb begin
        w_is_cond   = is_cond_branch(brOp);
        taken_d     = NextPCSrc;
        br_cnt_d    = br_cnt_q;
        taken_cnt_d = taken_cnt_q;
        if (w_is_cond) begin
            br_cnt_d = br_cnt_q + CNT_W'(1);
            if (NextPCSrc) begin
                taken_cnt_d = taken_cnt_q + CNT_W'(1);
            end
        end
    end

    // Statistics registers, cleared asynchronously while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_q     <= 1'b0;
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            taken_q     <= taken_d;
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign br_cnt    = br_cnt_q;
    assign taken_cnt = taken_cnt_q;

endmodule : bru
`default_nettype wire

// File: tb/tb_bru.sv
`default_nettype none
// ============================================================================
//  Module  : tb_bru
//  Brief   : Directed scoreboard bench for the branch resolution unit. A
//            full-width instance and a 4-bit-counter instance share stimulus
//            so counter wrap can be reached in a few cycles.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_bru;

    typedef struct packed {
        logic        tq;
        logic [31:0] br;
        logic [31:0] tk;
    } reg_exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] ru_rs1;
    logic [31:0] ru_rs2;
    logic [4:0]  brOp;
    logic        NextPCSrc;
    logic        taken_q;
    logic [31:0] br_cnt;
    logic [31:0] taken_cnt;
    logic        nps_w;
    logic        taken_q_w;
    logic [3:0]  br_cnt_w;
    logic [3:0]  taken_cnt_w;

    int          errors = 0;
    int          checks = 0;

    logic        q_comb[$];
    reg_exp_t    q_reg[$];

    // reference state
    logic        m_tq;
    logic [31:0] m_br;
    logic [31:0] m_tk;

    bru u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ru_rs1    (ru_rs1),
        .ru_rs2    (ru_rs2),
        .brOp      (brOp),
        .NextPCSrc (NextPCSrc),
        .taken_q   (taken_q),
        .br_cnt    (br_cnt),
        .taken_cnt (taken_cnt)
    );

    bru #(.XLEN(32), .CNT_W(4)) u_wrap (
        .clk       (clk),
        .rst_n     (rst_n),
        .ru_rs1    (ru_rs1),
        .ru_rs2    (ru_rs2),
        .brOp      (brOp),
        .NextPCSrc (nps_w),
        .taken_q   (taken_q_w),
        .br_cnt    (br_cnt_w),
        .taken_cnt (taken_cnt_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic ref_nps(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        casez (op)
            5'b1????: return 1'b1;
            5'b01000: return (a == b);
            5'b01001: return (a != b);
            5'b01100: return ($signed(a) <  $signed(b));
            5'b01101: return ($signed(a) >= $signed(b));
            5'b01110: return (a <  b);
            5'b01111: return (a >= b);
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic ref_cond(input logic [4:0] op);
        return (op == 5'b01000) || (op == 5'b01001) || (op[4:2] == 3'b011);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_comb(input string tag);
        logic e;
        if (q_comb.size() == 0) begin
            chk({tag, "/comb_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = q_comb.pop_front();
            chk({tag, "/NextPCSrc"},   32'(NextPCSrc), 32'(e));
            chk({tag, "/NextPCSrc_w"}, 32'(nps_w),     32'(e));
        end
    endtask

    task automatic check_regs(input string tag);
        reg_exp_t e;
        if (q_reg.size() == 0) begin
            chk({tag, "/reg_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = q_reg.pop_front();
            chk({tag, "/taken_q"},     32'(taken_q),     32'(e.tq));
            chk({tag, "/br_cnt"},      br_cnt,           e.br);
            chk({tag, "/taken_cnt"},   taken_cnt,        e.tk);
            chk({tag, "/taken_q_w"},   32'(taken_q_w),   32'(e.tq));
            chk({tag, "/br_cnt_w"},    32'(br_cnt_w),    32'(e.br[3:0]));
            chk({tag, "/taken_cnt_w"}, 32'(taken_cnt_w), 32'(e.tk[3:0]));
        end
    endtask

    // Called just after a negedge (or mid-cycle); drives one opcode for the
    // following rising edge and returns at the next negedge.
    task automatic step(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic e;
        brOp   = op;
        ru_rs1 = a;
        ru_rs2 = b;
        e = ref_nps(op, a, b);
        q_comb.push_back(e);
        if (rst_n) begin
            m_tq = e;
            if (ref_cond(op)) begin
                m_br = m_br + 32'd1;
                if (e) m_tk = m_tk + 32'd1;
            end
        end
        q_reg.push_back('{tq: m_tq, br: m_br, tk: m_tk});
        #1;
        check_comb(tag);
        @(posedge clk);
        #1;
        check_regs(tag);
        @(negedge clk);
    endtask

    // Assert reset between edges; registers must clear without a clock.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        m_tq = 1'b0;
        m_br = 32'd0;
        m_tk = 32'd0;
        q_reg.push_back('{tq: m_tq, br: m_br, tk: m_tk});
        #1;
        check_regs(tag);
    endtask

    // Directed sequence
    initial begin
        rst_n  = 1'b0;
        brOp   = 5'b00000;
        ru_rs1 = 32'd0;
        ru_rs2 = 32'd0;
        m_tq   = 1'b0;
        m_br   = 32'd0;
        m_tk   = 32'd0;

        q_reg.push_back('{tq: 1'b0, br: 32'd0, tk: 32'd0});
        #2;
        check_regs("reset_state");

        @(negedge clk);
        rst_n = 1'b1;

        step("beq_ne",      5'b01000, 32'd10, 32'd20);
        step("beq_eq",      5'b01000, 32'd10, 32'd10);
        step("bne_ne",      5'b01001, 32'd15, 32'd20);
        step("bne_eq",      5'b01001, 32'd7,  32'd7);
        step("blt_neg",     5'b01100, 32'hFFFF_FFFB, 32'd10);
        step("bltu_neg",    5'b01110, 32'hFFFF_FFFB, 32'd10);
        step("blt_rev",     5'b01100, 32'd10, 32'hFFFF_FFFB);
        step("bge_eq",      5'b01101, 32'd10, 32'd10);
        step("bge_neg",     5'b01101, 32'hFFFF_FFFB, 32'd10);
        step("bltu_small",  5'b01110, 32'd5,  32'd10);
        step("bgeu_big",    5'b01111, 32'd20, 32'd10);
        step("bgeu_small",  5'b01111, 32'd10, 32'd20);
        step("blt_minmax",  5'b01100, 32'h8000_0000, 32'h7FFF_FFFF);
        step("bltu_minmax", 5'b01110, 32'h8000_0000, 32'h7FFF_FFFF);
        step("none",        5'b00000, 32'd0,  32'd0);
        step("none_eq",     5'b00111, 32'd3,  32'd3);
        step("jal_x",       5'b10000, 32'hxxxx_xxxx, 32'hxxxx_xxxx);
        step("jalr_ones",   5'b11111, 32'd1,  32'd2);
        step("resv_01010",  5'b01010, 32'd10, 32'd10);
        step("resv_01011",  5'b01011, 32'd10, 32'd20);

        // counter scenario from a fresh reset
        async_reset("rst_pulse");
        @(negedge clk);
        rst_n = 1'b1;
        step("cnt_beq_t",   5'b01000, 32'd4,  32'd4);
        step("cnt_bne_nt",  5'b01001, 32'd4,  32'd4);
        step("cnt_jal",     5'b10000, 32'd0,  32'd0);
        step("cnt_none",    5'b00000, 32'd0,  32'd0);
        chk("cnt_br_eq_2",    br_cnt,    32'd2);
        chk("cnt_taken_eq_1", taken_cnt, 32'd1);

        // wrap on the 4-bit instance
        async_reset("rst_wrap");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step("wrap_fill", 5'b01000, 32'd9, 32'd9);
        end
        chk("wrap_allones_tk", 32'(taken_cnt_w), 32'd15);
        step("wrap_last",   5'b01000, 32'd9,  32'd9);
        chk("wrap_zero_tk",   32'(taken_cnt_w), 32'd0);
        chk("wrap_zero_br",   32'(br_cnt_w),    32'd0);
        chk("wrap_full_tk",   taken_cnt,        32'd16);

        // reset mid-cycle: registers clear at once, combinational path live
        async_reset("rst_mid");
        step("inrst_bltu",  5'b01110, 32'd5,  32'd10);
        step("inrst_beq",   5'b01000, 32'd1,  32'd2);
        rst_n = 1'b1;
        step("post_bge",    5'b01101, 32'd3,  32'd3);

        chk("q_comb_drained", 32'(q_comb.size()), 32'd0);
        chk("q_reg_drained",  32'(q_reg.size()),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_bru
`default_nettype wire
